// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, RGB332 colour constants
// and the peak-hold tuning used by the VU meter.
package vga_pkg;

  // Default 640x480@60 timing
  localparam int H_ADDR = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_ADDR = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  // RGB332 colours, packed as {red[2:0], green[2:0], blue[1:0]}
  localparam logic [7:0] BLACK  = 8'b000_000_00;
  localparam logic [7:0] GREEN  = 8'b000_111_00;
  localparam logic [7:0] YELLOW = 8'b111_111_00;
  localparam logic [7:0] RED    = 8'b111_000_00;
  localparam logic [7:0] WHITE  = 8'b111_111_11;

  // Peak-hold behaviour: frames a peak is held, rows it falls per frame,
  // and marker height in rows
  localparam int PEAK_HOLD_FRAMES = 30;
  localparam int PEAK_DECAY       = 4;
  localparam int PEAK_H           = 2;
  localparam int HOLD_W           = $clog2(PEAK_HOLD_FRAMES + 1);

  // Colour zone of a bar pixel, chosen by its height above the bottom
  typedef enum logic [1:0] {
    ZONE_GREEN,
    ZONE_YELLOW,
    ZONE_RED
  } zone_e;

endpackage

// File: rtl/vga_timing.sv
// Generic VGA timing generator: h/v counters, registered syncs, a registered
// frame_start pulse, plus combinational active-area and frame-tick flags
// describing the current counter position for downstream pixel logic.
module vga_timing
  import vga_pkg::*;
#(
  parameter int THADDR = H_ADDR,
  parameter int THFP   = H_FP,
  parameter int THS    = H_SYNC,
  parameter int THBP   = H_BP,
  parameter int TVADDR = V_ADDR,
  parameter int TVFP   = V_FP,
  parameter int TVS    = V_SYNC,
  parameter int TVBP   = V_BP,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0,
  parameter int C_SIZE = 10
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  output logic [C_SIZE-1:0] h_count,
  output logic [C_SIZE-1:0] v_count,
  output logic              active_area,
  output logic              frame_tick,
  output logic              h_sync,
  output logic              v_sync,
  output logic              frame_start
);

  localparam int HTOT = THADDR + THFP + THS + THBP;
  localparam int VTOT = TVADDR + TVFP + TVS + TVBP;

  localparam logic [C_SIZE-1:0] H_LAST     = C_SIZE'(HTOT - 1);
  localparam logic [C_SIZE-1:0] V_LAST     = C_SIZE'(VTOT - 1);
  localparam logic [C_SIZE-1:0] H_ACT      = C_SIZE'(THADDR);
  localparam logic [C_SIZE-1:0] V_ACT      = C_SIZE'(TVADDR);
  localparam logic [C_SIZE-1:0] H_SS       = C_SIZE'(THADDR + THFP);
  localparam logic [C_SIZE-1:0] H_SE       = C_SIZE'(THADDR + THFP + THS);
  localparam logic [C_SIZE-1:0] V_SS       = C_SIZE'(TVADDR + TVFP);
  localparam logic [C_SIZE-1:0] V_SE       = C_SIZE'(TVADDR + TVFP + TVS);
  localparam logic              H_ON       = (H_POL != 0);
  localparam logic              V_ON       = (V_POL != 0);

  // Raster counters: h wraps every line, v advances on each h wrap
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign active_area = (h_count < H_ACT) && (v_count < V_ACT);
  assign frame_tick  = (h_count == '0) && (v_count == V_ACT);

  // Syncs and frame_start registered from the current counters, one cycle late
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_sync      <= ~H_ON;
      v_sync      <= ~V_ON;
      frame_start <= 1'b0;
    end else begin
      h_sync      <= ((h_count >= H_SS) && (h_count < H_SE)) ? H_ON : ~H_ON;
      v_sync      <= ((v_count >= V_SS) && (v_count < V_SE)) ? V_ON : ~V_ON;
      frame_start <= frame_tick;
    end
  end

endmodule

// File: rtl/vga_vu_meter.sv
// Multi-channel VU meter drawn over VGA. Levels are double-buffered
// (shadow/active) so a new set only takes effect at the start of vertical
// blanking. Optional per-channel peak-hold markers are built when
// VU_PEAK_HOLD_EN is defined; otherwise only the bars are drawn.
module vga_vu_meter
  import vga_pkg::*;
#(
  parameter int THADDR  = H_ADDR,
  parameter int THFP    = H_FP,
  parameter int THS     = H_SYNC,
  parameter int THBP    = H_BP,
  parameter int TVADDR  = V_ADDR,
  parameter int TVFP    = V_FP,
  parameter int TVS     = V_SYNC,
  parameter int TVBP    = V_BP,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int C_SIZE  = 10,
  parameter int NUM_CH  = 4,
  parameter int DW      = 9,
  parameter int BAR_W   = 64,
  parameter int BAR_GAP = 16,
  parameter int YEL_TH  = 300,
  parameter int RED_TH  = 400
) (
  input  logic                 pixel_clock,
  input  logic                 reset_n,
  input  logic [NUM_CH*DW-1:0] levels,
  input  logic                 level_valid,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [2:0]           red,
  output logic [2:0]           green,
  output logic [1:0]           blue,
  output logic                 frame_start
);

  localparam int HTOT  = THADDR + THFP + THS + THBP;
  localparam int CH_W  = $clog2(NUM_CH + 1);
  localparam int SEG_W = $clog2(BAR_W + BAR_GAP);
  localparam int LW    = ((DW > C_SIZE) ? DW : C_SIZE) + 1;

  localparam logic [C_SIZE-1:0] H_LAST      = C_SIZE'(HTOT - 1);
  localparam logic [SEG_W-1:0]  MARGIN_LAST = SEG_W'(BAR_GAP - 1);
  localparam logic [SEG_W-1:0]  SLOT_LAST   = SEG_W'(BAR_W + BAR_GAP - 1);
  localparam logic [SEG_W-1:0]  BAR_END     = SEG_W'(BAR_W);
  localparam logic [CH_W-1:0]   CH_DONE     = CH_W'(NUM_CH);

  logic [C_SIZE-1:0] h_count;
  logic [C_SIZE-1:0] v_count;
  logic              active_area;
  logic              frame_tick;

  vga_timing #(
    .THADDR (THADDR), .THFP (THFP), .THS (THS), .THBP (THBP),
    .TVADDR (TVADDR), .TVFP (TVFP), .TVS (TVS), .TVBP (TVBP),
    .H_POL  (H_POL),  .V_POL (V_POL), .C_SIZE (C_SIZE)
  ) u_timing (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .h_count     (h_count),
    .v_count     (v_count),
    .active_area (active_area),
    .frame_tick  (frame_tick),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .frame_start (frame_start)
  );

  function automatic logic [DW-1:0] clamp_level(input logic [DW-1:0] lvl);
    if (LW'(lvl) >= LW'(TVADDR)) return DW'(TVADDR);
    return lvl;
  endfunction

  logic [DW-1:0] shadow  [NUM_CH];
  logic [DW-1:0] active  [NUM_CH];
  logic [DW-1:0] clamped [NUM_CH];

  // Clamped view of each shadow level, used whenever a frame's levels are taken
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) clamped[i] = clamp_level(shadow[i]);
  end

  // Shadow captures the producer's levels on any strobe
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (level_valid) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= levels[i*DW +: DW];
    end
  end

  // Active levels swap only at the first blanking line, so no frame tears;
  // a strobe on this same edge lands in shadow and waits a frame
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) active[i] <= '0;
    end else if (frame_tick) begin
      for (int i = 0; i < NUM_CH; i++) active[i] <= clamped[i];
    end
  end

  logic [SEG_W-1:0] seg_cnt;
  logic             in_margin;
  logic [CH_W-1:0]  ch_idx;

  // Column tracker: left margin, then BAR_W bar + BAR_GAP gap per channel,
  // parked once every channel has been drawn; state describes the current h
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_cnt   <= '0;
      in_margin <= 1'b1;
      ch_idx    <= '0;
    end else if (h_count == H_LAST) begin
      seg_cnt   <= '0;
      in_margin <= 1'b1;
      ch_idx    <= '0;
    end else if (in_margin) begin
      if (seg_cnt == MARGIN_LAST) begin
        seg_cnt   <= '0;
        in_margin <= 1'b0;
      end else begin
        seg_cnt <= seg_cnt + 1'b1;
      end
    end else if (ch_idx != CH_DONE) begin
      if (seg_cnt == SLOT_LAST) begin
        seg_cnt <= '0;
        ch_idx  <= ch_idx + 1'b1;
      end else begin
        seg_cnt <= seg_cnt + 1'b1;
      end
    end
  end

  logic [LW-1:0] row;
  logic          bar_col;
  logic [DW-1:0] cur_level;

  assign row     = LW'(TVADDR - 1) - LW'(v_count);
  assign bar_col = active_area && !in_margin && (ch_idx < CH_DONE) && (seg_cnt < BAR_END);

  // Select the active level of the channel under the beam
  always_comb begin
    cur_level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_W'(i)) cur_level = active[i];
    end
  end

  logic marker;

`ifdef VU_PEAK_HOLD_EN
  logic [DW-1:0]     peak      [NUM_CH];
  logic [HOLD_W-1:0] hold      [NUM_CH];
  logic [DW-1:0]     decay_base[NUM_CH];
  logic [DW-1:0]     decayed   [NUM_CH];
  logic [DW-1:0]     cur_peak;

  // Decayed peak, floored at zero and never below the incoming level
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      decay_base[i] = '0;
      if (LW'(peak[i]) > LW'(PEAK_DECAY)) decay_base[i] = peak[i] - DW'(PEAK_DECAY);
      decayed[i] = (clamped[i] > decay_base[i]) ? clamped[i] : decay_base[i];
    end
  end

  // Peak/hold update once per frame, alongside the active-level swap
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        peak[i] <= '0;
        hold[i] <= '0;
      end
    end else if (frame_tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clamped[i] >= peak[i]) begin
          peak[i] <= clamped[i];
          hold[i] <= HOLD_W'(PEAK_HOLD_FRAMES);
        end else if (hold[i] != '0) begin
          hold[i] <= hold[i] - 1'b1;
        end else begin
          peak[i] <= decayed[i];
        end
      end
    end
  end

  // Select the peak of the channel under the beam
  always_comb begin
    cur_peak = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_W'(i)) cur_peak = peak[i];
    end
  end

  assign marker = bar_col && (cur_peak != '0) && (row < LW'(cur_peak)) &&
                  ((row + LW'(PEAK_H)) >= LW'(cur_peak));
`else
  assign marker = 1'b0;
`endif

  zone_e      zone;
  logic [7:0] pixel_next;

  // Colour mux: peak marker over zone colour over black
  always_comb begin
    zone       = ZONE_GREEN;
    pixel_next = BLACK;
    if (row >= LW'(RED_TH))      zone = ZONE_RED;
    else if (row >= LW'(YEL_TH)) zone = ZONE_YELLOW;
    if (marker) begin
      pixel_next = WHITE;
    end else if (bar_col && (row < LW'(cur_level))) begin
      case (zone)
        ZONE_RED:    pixel_next = RED;
        ZONE_YELLOW: pixel_next = YELLOW;
        default:     pixel_next = GREEN;
      endcase
    end
  end

  // Colour register, aligned with the registered syncs
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) {red, green, blue} <= BLACK;
    else          {red, green, blue} <= pixel_next;
  end

endmodule
